// File: rtl/config_reg_arbiter.sv
// Round-robin arbiter sharing the config register file port between
// the host bus (port 0) and the calibration engine (port 1), with write readback verify.
module config_reg_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int RD_LAT    = 1,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_err,
  output logic [7:0]        err_count,
  output logic              cfg_write,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [DATA_W-1:0] cfg_data_in,
  input  logic [DATA_W-1:0] cfg_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              take;
  logic              sel;
  logic              gnt;
  logic              rr_ptr;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        cnt;
  logic [7:0]        err_q;
  logic              in_resp;
  logic              mismatch;

  // Next-state and grant selection; a lone requester wins, a tie goes to rr_ptr
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    sel      = rr_ptr;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          take     = 1'b1;
          sel      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (cnt == 3'd1) state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Transaction latch, read-latency counter, readback capture and error count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= 1'b0;
      rr_ptr  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= 3'd0;
      err_q   <= 8'd0;
    end else begin
      if (take) begin
        gnt     <= sel;
        wr_q    <= sel ? req1_write : req0_write;
        addr_q  <= sel ? req1_addr : req0_addr;
        wdata_q <= sel ? req1_wdata : req0_wdata;
      end
      if (state == ISSUE) cnt <= 3'(RD_LAT);
      if (state == WAIT) begin
        cnt <= 3'(cnt - 3'd1);
        if (cnt == 3'd1) rdata_q <= cfg_data_out;
      end
      if (in_resp) begin
        rr_ptr <= ~gnt;
        if (wr_err && err_q != 8'hFF) err_q <= 8'(err_q + 8'd1);
      end
    end
  end

  assign in_resp  = (state == RESP);
  assign mismatch = (rdata_q != wdata_q);

  assign req0_ready  = take & ~sel & ~reset;
  assign req1_ready  = take & sel & ~reset;
  assign req0_rvalid = in_resp & ~gnt;
  assign req1_rvalid = in_resp & gnt;
  assign wr_err      = in_resp & (VERIFY_EN != 0) & wr_q & mismatch;
  assign err_count   = err_q;
  assign rdata       = rdata_q;
  assign cfg_write   = (state == ISSUE) & wr_q;
  assign cfg_address = addr_q;
  assign cfg_data_in = wdata_q;
  assign busy        = (state != IDLE);

endmodule
